switch_debounce: RTL and testbench

SWITCH_DEBOUNCE -- requirements
Module: switch_debounce

---
 rtl/switch_debounce.sv | 86 ++++++++
 tb/tb_switch_debounce.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// Multi-channel switch debouncer: a two-flop synchronizer and a stability counter per
// channel, registered rise/fall pulses, and a sticky "changed" flag across all channels.

module switch_debounce_lane #(
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic clean,
  output logic rise,
  output logic fall
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1, s2;
  logic          clean_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1      <= RST_VAL;
      s2      <= RST_VAL;
      clean   <= RST_VAL;
      clean_d <= RST_VAL;
      cnt     <= '0;
      rise    <= 1'b0;
      fall    <= 1'b0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      clean_d <= clean;
      // Edge detect on the accepted level: pulse lands one cycle after clean moves.
      rise    <= clean & ~clean_d;
      fall    <= ~clean & clean_d;
      if (s2 == clean)
        cnt <= '0;
      else if (cnt == CNT_MAX) begin
        clean <= s2;
        cnt   <= '0;
      end else
        cnt <= cnt + CW'(1);
    end
  end
endmodule

module switch_debounce #(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 1000000,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_clean,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall,
  output logic             changed,
  input  logic             changed_clr
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane
    switch_debounce_lane #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_VAL         (RESET_VALUE[i])
    ) u_lane (
      .clk   (clk_clk),
      .rst   (reset_reset),
      .raw   (sw_raw[i]),
      .clean (sw_clean[i]),
      .rise  (sw_rise[i]),
      .fall  (sw_fall[i])
    );
  end

  // Set has priority over clear so a pulse coinciding with a clear is never lost.
  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      changed <= 1'b0;
    else if (|{sw_rise, sw_fall})
      changed <= 1'b1;
    else if (changed_clr)
      changed <= 1'b0;
  end
endmodule

// File: tb/tb_switch_debounce.sv
// Directed bench for switch_debounce with DEBOUNCE_CYCLES=4, WIDTH=4, RESET_VALUE=0.

module tb_switch_debounce;
  logic       clk_clk = 1'b0;
  logic       reset_reset;
  logic [3:0] sw_raw;
  logic [3:0] sw_clean, sw_rise, sw_fall;
  logic       changed, changed_clr;

  int n_chk = 0;
  int n_err = 0;

  switch_debounce #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .RESET_VALUE     (4'b0000)
  ) dut (
    .clk_clk     (clk_clk),
    .reset_reset (reset_reset),
    .sw_raw      (sw_raw),
    .sw_clean    (sw_clean),
    .sw_rise     (sw_rise),
    .sw_fall     (sw_fall),
    .changed     (changed),
    .changed_clr (changed_clr)
  );

  always #5 clk_clk = ~clk_clk;

  task automatic tick;
    @(posedge clk_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    reset_reset = 1'b1;
    sw_raw      = 4'b0000;
    changed_clr = 1'b0;

    // Reset state and idle hold
    tick; tick;
    chk("rst_state", {sw_clean, sw_rise, sw_fall, changed}, 32'h0);
    reset_reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick;
      chk("idle", {sw_clean, sw_rise, sw_fall, changed}, 32'h0);
    end

    // Single channel rise: clean on edge 6 (5 edges after first sample), pulse on edge 7
    sw_raw = 4'b0001;
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk("b_wait", sw_clean, 32'h0);
    end
    tick;
    chk("b_clean", sw_clean, 32'h1);
    chk("b_norise", sw_rise, 32'h0);
    tick;
    chk("b_rise", sw_rise, 32'h1);
    chk("b_chg_pre", changed, 32'h0);
    tick;
    chk("b_rise_off", sw_rise, 32'h0);
    chk("b_chg", changed, 32'h1);
    repeat (3) tick;
    chk("b_chg_hold", changed, 32'h1);
    chk("b_clean_hold", sw_clean, 32'h1);

    // Bounce with 3-cycle highs never reaches the threshold
    sw_raw = 4'b0000;
    reset_reset = 1'b1;
    tick;
    reset_reset = 1'b0;
    for (int p = 0; p < 4; p++) begin
      sw_raw[1] = (p % 2 == 0);
      for (int k = 0; k < 3; k++) begin
        tick;
        chk("c_bounce", {sw_clean, sw_rise, sw_fall, changed}, 32'h0);
      end
    end
    sw_raw = 4'b0000;
    for (int k = 0; k < 8; k++) begin
      tick;
      chk("c_settle", {sw_clean, sw_rise, sw_fall, changed}, 32'h0);
    end

    // Two channels at once, up then down
    sw_raw = 4'b1010;
    repeat (5) tick;
    chk("d_wait", sw_clean, 32'h0);
    tick;
    chk("d_clean", sw_clean, 32'hA);
    chk("d_norise", sw_rise, 32'h0);
    tick;
    chk("d_rise", sw_rise, 32'hA);
    chk("d_nofall", sw_fall, 32'h0);
    tick;
    chk("d_rise_off", sw_rise, 32'h0);
    chk("d_chg", changed, 32'h1);
    sw_raw = 4'b0000;
    repeat (5) tick;
    chk("d_hold", sw_clean, 32'hA);
    tick;
    chk("d_clean0", sw_clean, 32'h0);
    chk("d_nofall0", sw_fall, 32'h0);
    tick;
    chk("d_fall", sw_fall, 32'hA);
    chk("d_norise2", sw_rise, 32'h0);
    tick;
    chk("d_fall_off", sw_fall, 32'h0);

    // Clear coinciding with a new pulse loses to the set; clear alone wins
    sw_raw = 4'b0100;
    repeat (6) tick;
    chk("e_clean", sw_clean, 32'h4);
    tick;
    chk("e_rise", sw_rise, 32'h4);
    changed_clr = 1'b1;
    tick;
    chk("e_set_wins", changed, 32'h1);
    tick;
    chk("e_clr", changed, 32'h0);
    changed_clr = 1'b0;
    tick;
    chk("e_stay", changed, 32'h0);

    // Reset mid-count discards the pending edge; then a full debounce after release
    sw_raw = 4'b0000;
    reset_reset = 1'b1;
    tick;
    reset_reset = 1'b0;
    chk("f_rst0", {sw_clean, changed}, 32'h0);
    sw_raw = 4'b0100;
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("f_pre", {sw_clean, sw_rise}, 32'h0);
    end
    reset_reset = 1'b1;
    tick;
    chk("f_rst", {sw_clean, sw_rise, sw_fall, changed}, 32'h0);
    reset_reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick;
      chk("f_wait", {sw_clean, sw_rise}, 32'h0);
    end
    tick;
    chk("f_clean", sw_clean, 32'h4);
    chk("f_norise", sw_rise, 32'h0);
    tick;
    chk("f_rise", sw_rise, 32'h4);
    tick;
    chk("f_rise_off", sw_rise, 32'h0);
    chk("f_chg", changed, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
